control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/cpu_ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_outdec.sv | 37 +++
 rtl/control_fsm.sv | 93 +++++++++
 tb/tb_control_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, opcode, op, nsel and vsel constants plus the control word type
// Imported by control_fsm, ctrl_outdec and by decoder/datapath users.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST    = 5'd0,
    S_IF1    = 5'd1,
    S_IF2    = 5'd2,
    S_UPDPC  = 5'd3,
    S_DECODE = 5'd4,
    S_WRIMM  = 5'd5,
    S_GETA   = 5'd6,
    S_GETB   = 5'd7,
    S_ALUC   = 5'd8,
    S_CMPS   = 5'd9,
    S_WRRD   = 5'd10,
    S_ADDR   = 5'd11,
    S_LDADDR = 5'd12,
    S_MRD1   = 5'd13,
    S_MRD2   = 5'd14,
    S_GETBD  = 5'd15,
    S_PASSB  = 5'd16,
    S_MWR    = 5'd17,
    S_HALT   = 5'd18
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_STR = 3'b100;
  localparam logic [2:0] OPC_LDR = 3'b011;
  localparam logic [2:0] OPC_HLT = 3'b111;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_CMP    = 2'b01;
  localparam logic [1:0] OP_AND    = 2'b10;
  localparam logic [1:0] OP_MVN    = 2'b11;
  localparam logic [1:0] OP_MOVIMM = 2'b10;
  localparam logic [1:0] OP_MOVREG = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b00;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_MDATA     = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8    = 2'b01;
  localparam logic [1:0] VSEL_ZEROANDPC = 2'b10;
  localparam logic [1:0] VSEL_C         = 2'b11;

  typedef struct packed {
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       loadpc;
    logic       msel;
    logic       mwrite;
    logic       loadir;
    logic       loadaddr;
    logic       halted;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_outdec.sv
// rtl/ctrl_outdec.sv - combinational decode of the state register into the control word
// Ports: state (current state), opcode (instruction register opcode field, used only in ALUC),
//        cw (control word; every field 0 unless the state asserts it).
module ctrl_outdec
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] opcode,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_IF1:    cw.msel = 1'b0;
      S_IF2:    begin cw.msel = 1'b0; cw.loadir = 1'b1; end
      S_UPDPC:  cw.loadpc = 1'b1;
      S_WRIMM:  begin cw.nsel = NSEL_RN; cw.vsel = VSEL_SXIMM8; cw.write = 1'b1; end
      S_GETA:   begin cw.nsel = NSEL_RN; cw.loada = 1'b1; end
      S_GETB:   begin cw.nsel = NSEL_RM; cw.loadb = 1'b1; end
      // MOV reg passes B through with A forced to zero, so only it sets asel here
      S_ALUC:   begin cw.loadc = 1'b1; cw.asel = (opcode == OPC_MOV); end
      S_CMPS:   cw.loads = 1'b1;
      S_WRRD:   begin cw.nsel = NSEL_RD; cw.vsel = VSEL_C; cw.write = 1'b1; end
      S_ADDR:   begin cw.bsel = 1'b1; cw.loadc = 1'b1; end
      S_LDADDR: cw.loadaddr = 1'b1;
      S_MRD1:   cw.msel = 1'b1;
      S_MRD2:   begin cw.msel = 1'b1; cw.nsel = NSEL_RD; cw.vsel = VSEL_MDATA; cw.write = 1'b1; end
      S_GETBD:  begin cw.nsel = NSEL_RD; cw.loadb = 1'b1; end
      S_PASSB:  begin cw.asel = 1'b1; cw.loadc = 1'b1; end
      S_MWR:    begin cw.msel = 1'b1; cw.mwrite = 1'b1; end
      S_HALT:   cw.halted = 1'b1;
      default:  cw = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// rtl/control_fsm.sv - Moore controller for fetch/decode/execute of MOV, ALU, LDR, STR, HLT
// Ports: clk, reset (async, active-high), opcode/op (instruction fields),
//        nsel/vsel and 1-bit datapath/memory strobes, halted, state (debug).
module control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       loadpc,
  output logic       msel,
  output logic       mwrite,
  output logic       loadir,
  output logic       loadaddr,
  output logic       halted,
  output logic [4:0] state
);

  state_t     st;
  ctrl_word_t cw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= S_RST;
    end else begin
      case (st)
        S_RST:    st <= S_IF1;
        S_IF1:    st <= S_IF2;
        S_IF2:    st <= S_UPDPC;
        S_UPDPC:  st <= S_DECODE;
        S_DECODE: begin
          // Unsupported combinations fall back to fetch without touching the datapath
          if (opcode == OPC_MOV && op == OP_MOVIMM)      st <= S_WRIMM;
          else if (opcode == OPC_MOV && op == OP_MOVREG) st <= S_GETB;
          else if (opcode == OPC_ALU)                    st <= S_GETA;
          else if (opcode == OPC_LDR && op == OP_MEM)    st <= S_GETA;
          else if (opcode == OPC_STR && op == OP_MEM)    st <= S_GETA;
          else if (opcode == OPC_HLT)                    st <= S_HALT;
          else                                           st <= S_IF1;
        end
        S_WRIMM:  st <= S_IF1;
        S_GETA:   st <= (opcode == OPC_ALU) ? S_GETB : S_ADDR;
        S_GETB:   st <= (opcode == OPC_ALU && op == OP_CMP) ? S_CMPS : S_ALUC;
        S_ALUC:   st <= S_WRRD;
        S_CMPS:   st <= S_IF1;
        S_WRRD:   st <= S_IF1;
        S_ADDR:   st <= S_LDADDR;
        S_LDADDR: st <= (opcode == OPC_LDR) ? S_MRD1 : S_GETBD;
        S_MRD1:   st <= S_MRD2;
        S_MRD2:   st <= S_IF1;
        S_GETBD:  st <= S_PASSB;
        S_PASSB:  st <= S_MWR;
        S_MWR:    st <= S_IF1;
        S_HALT:   st <= S_HALT;
        default:  st <= S_RST;
      endcase
    end
  end

  ctrl_outdec u_outdec (
    .state  (st),
    .opcode (opcode),
    .cw     (cw)
  );

  assign state    = st;
  assign nsel     = cw.nsel;
  assign vsel     = cw.vsel;
  assign loada    = cw.loada;
  assign loadb    = cw.loadb;
  assign asel     = cw.asel;
  assign bsel     = cw.bsel;
  assign loadc    = cw.loadc;
  assign loads    = cw.loads;
  assign write    = cw.write;
  assign loadpc   = cw.loadpc;
  assign msel     = cw.msel;
  assign mwrite   = cw.mwrite;
  assign loadir   = cw.loadir;
  assign loadaddr = cw.loadaddr;
  assign halted   = cw.halted;

endmodule

// File: tb/tb_control_fsm.sv
// tb/tb_control_fsm.sv - scoreboard bench for control_fsm with a per-instruction reference model
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic [1:0] nsel, vsel;
  logic       loada, loadb, asel, bsel, loadc, loads, write, loadpc;
  logic       msel, mwrite, loadir, loadaddr, halted;
  logic [4:0] state;

  control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .write(write), .loadpc(loadpc), .msel(msel),
    .mwrite(mwrite), .loadir(loadir), .loadaddr(loadaddr), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // flag bits of the expected record, low 13 bits of the control word
  localparam logic [12:0] LA = 13'h1000, LB = 13'h0800, AS = 13'h0400, BS = 13'h0200;
  localparam logic [12:0] LC = 13'h0100, LS = 13'h0080, WR = 13'h0040, LP = 13'h0020;
  localparam logic [12:0] MS = 13'h0010, MW = 13'h0008, LI = 13'h0004, LD = 13'h0002;
  localparam logic [12:0] HT = 13'h0001;

  typedef struct packed {
    logic [4:0]  st;
    logic [16:0] cw;
  } rec_t;

  rec_t q[$];
  bit   mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  wire [16:0] dut_cw = {nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write,
                        loadpc, msel, mwrite, loadir, loadaddr, halted};

  function automatic void rec(input int st, input logic [1:0] ns, input logic [1:0] vs,
                              input logic [12:0] fl);
    rec_t r;
    r.st = 5'(st);
    r.cw = {ns, vs, fl};
    q.push_back(r);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from fetch to the cycle before next IF1
  function automatic void push_instr(input logic [2:0] opc, input logic [1:0] o);
    rec(1, 0, 0, 0);
    rec(2, 0, 0, LI);
    rec(3, 0, 0, LP);
    rec(4, 0, 0, 0);
    if (opc == 3'b110 && o == 2'b10) begin
      rec(5, 2'b00, 2'b01, WR);
    end else if (opc == 3'b110 && o == 2'b00) begin
      rec(7, 2'b10, 0, LB);
      rec(8, 0, 0, LC | AS);
      rec(10, 2'b01, 2'b11, WR);
    end else if (opc == 3'b101) begin
      rec(6, 2'b00, 0, LA);
      rec(7, 2'b10, 0, LB);
      if (o == 2'b01) rec(9, 0, 0, LS);
      else begin
        rec(8, 0, 0, LC);
        rec(10, 2'b01, 2'b11, WR);
      end
    end else if ((opc == 3'b011 || opc == 3'b100) && o == 2'b00) begin
      rec(6, 2'b00, 0, LA);
      rec(11, 0, 0, BS | LC);
      rec(12, 0, 0, LD);
      if (opc == 3'b011) begin
        rec(13, 0, 0, MS);
        rec(14, 2'b01, 2'b00, MS | WR);
      end else begin
        rec(15, 2'b01, 0, LB);
        rec(16, 0, 0, AS | LC);
        rec(17, 0, 0, MS | MW);
      end
    end else if (opc == 3'b111) begin
      for (int i = 0; i < 20; i++) rec(18, 0, 0, HT);
    end
  endfunction

  // Monitor: compares every cycle against the scoreboard while enabled
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL underflow: got state=%0d cw=%h, required no activity queued", state, dut_cw);
        end else begin
          e = q.pop_front();
          if (state !== e.st || dut_cw !== e.cw) begin
            n_bad++;
            $display("FAIL step: got state=%0d cw=%h, required state=%0d cw=%h",
                     state, dut_cw, e.st, e.cw);
          end
        end
      end
    end
  end

  task automatic check_zero(input string name);
    n_cmp++;
    if (state !== 5'd0 || dut_cw !== 17'd0) begin
      n_bad++;
      $display("FAIL %s: got state=%0d cw=%h, required state=0 cw=00000", name, state, dut_cw);
    end
  endtask

  task automatic start_instr(input logic [2:0] opc, input logic [1:0] o);
    opcode = opc;
    op = o;
    push_instr(opc, o);
    mon_en = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d records pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic next_instr(input logic [2:0] opc, input logic [1:0] o);
    wait_drain();
    @(posedge clk);
    #1;
    start_instr(opc, o);
  endtask

  // Reset held across edges, released just after a falling edge so the next rising edge enters IF1
  task automatic do_reset(input logic [2:0] opc, input logic [1:0] o);
    mon_en = 1'b0;
    q.delete();
    reset = 1'b1;
    #1;
    check_zero("reset_async");
    repeat (2) begin
      @(negedge clk);
      check_zero("reset_held");
    end
    #1;
    reset = 1'b0;
    start_instr(opc, o);
  endtask

  initial begin
    logic [2:0] ro;
    logic [1:0] rp;
    int n;
    #2;
    check_zero("reset_initial");
    do_reset(3'b110, 2'b10);
    next_instr(3'b101, 2'b01);
    next_instr(3'b100, 2'b00);
    next_instr(3'b011, 2'b00);
    next_instr(3'b110, 2'b00);
    next_instr(3'b101, 2'b00);
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 6));
      rp = 2'($urandom_range(0, 3));
      next_instr(ro, rp);
    end

    // abort a store in PASSB
    wait_drain();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    opcode = 3'b100;
    op = 2'b00;
    n = 0;
    while (state != 5'd16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (state != 5'd16) begin
      n_bad++;
      $display("FAIL reach_passb: got state=%0d, required 16", state);
    end
    #2;
    do_reset(3'b110, 2'b10);

    // halt is sticky for 20 cycles, then reset and an unsupported opcode
    next_instr(3'b111, 2'($urandom_range(0, 3)));
    wait_drain();
    #1;
    n_cmp++;
    if (halted !== 1'b1 || state !== 5'd18) begin
      n_bad++;
      $display("FAIL halt_sticky: got state=%0d halted=%b, required state=18 halted=1", state, halted);
    end
    do_reset(3'b001, 2'($urandom_range(0, 3)));
    next_instr(3'b110, 2'b10);
    wait_drain();
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
